pipelined_datapath: RTL
=======================

Name: pipelined_datapath

Overview:
Parametrised two-stage successor to the single-cycle register-file/ALU/data-memory datapath. It accepts one instruction per cycle over a valid/ready handshake and reads operands in ISSUE. It executes the ALU or memory access in EX and writes back at the end of EX, with an EX-to-ISSUE bypass so back-to-back dependent instructions never stall. After reset, a clear sequencer zeroes data memory before accepting work. It also exposes a registered write-back observation port, status flags and a retire counter.

Parameters:
DATA_W, 4, datapath and register width
REG_N, 8, number of registers; RA_W = $clog2(REG_N)
MEM_DEPTH, 16, data memory words; AD_W = $clog2(MEM_DEPTH)
CNT_W, 16, retire counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction present
in_ready  out  1  block can accept (0 during CLEAR)
in_kind  in  2  0 ALU, 1 LOAD, 2 STORE, 3 LDI
in_op  in  3  ALU opcode (ALU kind only)
in_r1  in  RA_W  source A / store-data register
in_r2  in  RA_W  source B
in_rw  in  RA_W  destination register
in_addr  in  AD_W  memory address (LOAD/STORE)
in_imm  in  DATA_W  immediate (LDI)
wb_valid  out  1  a register write completed last edge
wb_addr  out  RA_W  register written
wb_data  out  DATA_W  value written
flag_z  out  1  last written result == 0
flag_c  out  1  carry/borrow of last ADD/SUB
retire_cnt  out  CNT_W  instructions retired, wraps

Behaviour:
- Reset (sync, high), applied on the clocking edge: all registers := 0; EX valid := 0; FSM := CLEAR with clr_ptr := 0; all outputs 0 (in_ready 0).
- CLEAR state: writes mem[clr_ptr] := 0 each cycle and increments clr_ptr; after writing MEM_DEPTH-1 -> RUN. Takes exactly MEM_DEPTH cycles; in_ready = 1 from the next cycle.
- Reset during CLEAR restarts the clear at 0.
- RUN: in_ready = 1 always. Accept = in_valid & in_ready.
- ISSUE (accept cycle N): read R[r1] and R[r2] combinationally.
  - Bypass: if EX is valid, EX writes a register, and ex_rw matches r1 (r2), substitute the EX result.
  - Operands and fields are latched into the EX register.
- EX (cycle N+1):
  - ALU ops (A=op1, B=op2, DATA_W-bit, modulo 2^DATA_W): 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL A by 1, 6 SHR A by 1 logical, 7 PASS A.
  - LOAD result = mem[addr], asynchronous array read.
  - STORE writes mem[addr] := op1 at the end of N+1 and writes no register.
  - LDI result = imm.
- End of N+1:
  - Register write R[rw] := result for ALU, LOAD and LDI.
  - wb_valid := 1 with wb_addr and wb_data, visible in N+2; wb_valid := 0 the next cycle if no write.
  - flag_z updates on every register write.
  - flag_c updates only on ADD (carry out) and SUB (1 = borrow, A<B); it holds otherwise.
  - retire_cnt += 1 for every EX-valid instruction, including STORE; wraps at 2^CNT_W.
- A STORE in EX at N+1 followed by a LOAD of the same address in EX at N+2 returns the stored value, since the memory write is visible the next cycle.
- Back-to-back writes to the same rw: the later instruction wins.
- Reset mid-operation: the EX instruction is discarded with no register or memory write; the FSM reenters CLEAR.
- No backpressure on the wb port.

Decomposition:
- Package dp_pkg:
  - kind_t enum (K_ALU, K_LOAD, K_STORE, K_LDI)
  - alu_op_t enum (ADD..PASS)
  - state_t enum (CLEAR, RUN)
- Sub-module dp_alu: combinational, parametrised by DATA_W; outputs result and carry.
- Register file, memory, bypass and FSM stay in pipelined_datapath.

Test Plan:
- Reset, MEM_DEPTH=16 -> in_ready low for exactly 16 cycles, then high; a LOAD of any address returns 0; all outputs 0 during clear.
- LDI R1=5; LDI R2=3; ADD R3=R1+R2; SUB R4=R3-R2, back to back -> wb_data 5, 3, 8, 5 on consecutive cycles (bypass exercised); flag_c=0.
- LDI R1=2; LDI R2=3; SUB R5=R1-R2 -> wb_data 15 (4-bit), flag_c=1, flag_z=0; XOR R6=R5,R5 -> 0 with flag_z=1, flag_c unchanged (1).
- LDI R1=9; STORE [7]=R1; LOAD R2=[7] back to back -> wb R2=9; retire_cnt = 3.
- LDI R1=15; ADD R1=R1+R1 -> wb_data 14, flag_c=1; SHR R1 -> 7.
- Reset asserted the cycle a STORE [3] is in EX -> after the clear, LOAD [3]=0; retire_cnt = 0.

Source files
------------

// File: rtl/dp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dp_pkg                                                      |
// | Desc   : Shared types for the pipelined register/ALU/memory datapath |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package dp_pkg;

    typedef enum logic [1:0] {
        K_ALU   = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2,
        K_LDI   = 2'd3
    } kind_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dp_if                                                       |
// | Desc   : Instruction handshake and write-back observation bundle     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface dp_if #(
    parameter int DATA_W    = 4,
    parameter int REG_N     = 8,
    parameter int MEM_DEPTH = 16,
    parameter int CNT_W     = 16
);
    localparam int RA_W = $clog2(REG_N);
    localparam int AD_W = $clog2(MEM_DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [2:0]        in_op;
    logic [RA_W-1:0]   in_r1;
    logic [RA_W-1:0]   in_r2;
    logic [RA_W-1:0]   in_rw;
    logic [AD_W-1:0]   in_addr;
    logic [DATA_W-1:0] in_imm;
    logic              wb_valid;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flag_z;
    logic              flag_c;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output in_valid, in_kind, in_op, in_r1, in_r2, in_rw, in_addr, in_imm,
        input  in_ready, wb_valid, wb_addr, wb_data, flag_z, flag_c, retire_cnt
    );

    modport slave (
        input  in_valid, in_kind, in_op, in_r1, in_r2, in_rw, in_addr, in_imm,
        output in_ready, wb_valid, wb_addr, wb_data, flag_z, flag_c, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dp_alu                                                      |
// | Desc   : Combinational ALU with carry/borrow for ADD and SUB         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // Top bit of the widened difference is the borrow (A < B).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD:  {o_carry, o_result} = w_sum;
            OP_SUB:  {o_carry, o_result} = w_diff;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = {i_a[DATA_W-2:0], 1'b0};
            OP_SHR:  o_result = {1'b0, i_a[DATA_W-1:1]};
            OP_PASS: o_result = i_a;
            default: o_result = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/pipelined_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pipelined_datapath                                          |
// | Desc   : Two-stage ISSUE/EX datapath with bypass and memory clear    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module pipelined_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int REG_N     = 8,
    parameter int MEM_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    dp_if.slave  bus
);
    localparam int RA_W = $clog2(REG_N);
    localparam int AD_W = $clog2(MEM_DEPTH);
    localparam logic [0:0]      c_ST_CLEAR = ST_CLEAR;
    localparam logic [0:0]      c_ST_RUN   = ST_RUN;
    localparam logic [AD_W-1:0] c_CLR_LAST = AD_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] r_regs [REG_N];
    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];
    logic [0:0]        r_state;
    logic [AD_W-1:0]   r_clr_ptr;

    logic              r_ex_valid;
    kind_t             r_ex_kind;
    alu_op_t           r_ex_op;
    logic [DATA_W-1:0] r_ex_op1;
    logic [DATA_W-1:0] r_ex_op2;
    logic [RA_W-1:0]   r_ex_rw;
    logic [AD_W-1:0]   r_ex_addr;
    logic [DATA_W-1:0] r_ex_imm;

    logic              r_wb_valid;
    logic [RA_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_flag_z;
    logic              r_flag_c;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_ex_wr;
    logic              w_ex_addsub;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic [DATA_W-1:0] w_ex_result;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    assign w_ready     = (r_state == c_ST_RUN);
    assign w_accept    = bus.in_valid & w_ready;
    assign w_ex_wr     = r_ex_valid && (r_ex_kind != K_STORE);
    assign w_ex_addsub = r_ex_valid && (r_ex_kind == K_ALU) &&
                         ((r_ex_op == OP_ADD) || (r_ex_op == OP_SUB));

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_ex_op),
        .i_a      (r_ex_op1),
        .i_b      (r_ex_op2),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    always_comb begin
        w_ex_result = '0;
        case (r_ex_kind)
            K_ALU:   w_ex_result = w_alu_result;
            K_LOAD:  w_ex_result = r_mem[r_ex_addr];
            K_LDI:   w_ex_result = r_ex_imm;
            default: w_ex_result = '0;
        endcase
    end

    // The EX result is forwarded so a dependent instruction issued the very
    // next cycle sees the value being written this edge.
    always_comb begin
        w_op1 = r_regs[bus.in_r1];
        w_op2 = r_regs[bus.in_r2];
        if (w_ex_wr && (r_ex_rw == bus.in_r1)) w_op1 = w_ex_result;
        if (w_ex_wr && (r_ex_rw == bus.in_r2)) w_op2 = w_ex_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
            if (r_clr_ptr == c_CLR_LAST) r_state <= c_ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_ST_CLEAR)
                r_mem[r_clr_ptr] <= '0;
            else if (r_ex_valid && (r_ex_kind == K_STORE))
                r_mem[r_ex_addr] <= r_ex_op1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
        end else if (w_ex_wr) begin
            r_regs[r_ex_rw] <= w_ex_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_kind  <= K_ALU;
            r_ex_op    <= OP_ADD;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_rw    <= '0;
            r_ex_addr  <= '0;
            r_ex_imm   <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_kind <= kind_t'(bus.in_kind);
                r_ex_op   <= alu_op_t'(bus.in_op);
                r_ex_op1  <= w_op1;
                r_ex_op2  <= w_op2;
                r_ex_rw   <= bus.in_rw;
                r_ex_addr <= bus.in_addr;
                r_ex_imm  <= bus.in_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_wb_valid <= w_ex_wr;
            if (w_ex_wr) begin
                r_wb_addr <= r_ex_rw;
                r_wb_data <= w_ex_result;
                r_flag_z  <= (w_ex_result == '0);
            end
            if (w_ex_addsub) r_flag_c <= w_alu_carry;
            if (r_ex_valid) r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_addr    = r_wb_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.flag_z     = r_flag_z;
    assign bus.flag_c     = r_flag_c;
    assign bus.retire_cnt = r_retire_cnt;
endmodule
`default_nettype wire
